// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes and FSM state shared by alu_seq and its bench
// Purpose: single source for the 4-bit opcode encodings and the sequencer
//          state enum of alu_seq.
// Ports:   none (package).
// Config:  OP_MUL and the BUSY/DONE states are used only when ALU_SEQ_MUL_EN
//          is defined.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative unsigned shift-add multiplier, one bit per cycle
// Purpose: multiplies a by b over WIDTH iterations. start loads the operands
//          and clears the iteration counter; each cycle with run high retires
//          one multiplier bit. done flags the cycle in which the last
//          iteration is being performed (counter == WIDTH-1).
// Ports:   clk, rst (sync, active high)
//          start            load a/b and clear the counter
//          a, b [WIDTH]     multiplicand / multiplier
//          run              perform one iteration this cycle
//          done             last iteration happens on the coming edge
//          product_lo [W]   low WIDTH bits of the product
//          product_hi_nz    high WIDTH bits of the product are nonzero
// Config:  instantiated only when ALU_SEQ_MUL_EN is defined.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             run,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic             product_hi_nz
);

  logic [WIDTH-1:0]   count;
  logic [WIDTH-1:0]   mcand;
  // {partial product high half, remaining multiplier bits}; the multiplier is
  // consumed from the bottom while product bits shift in from the top.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     partial;

  always_comb begin
    partial = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) begin
      partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      mcand <= '0;
      acc   <= '0;
    end else if (start) begin
      count <= '0;
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
    end else if (run) begin
      acc   <= {partial, acc[WIDTH-1:1]};
      count <= count + WIDTH'(1);
    end
  end

  assign done          = run && (count == WIDTH'(WIDTH - 1));
  assign product_lo    = acc[WIDTH-1:0];
  assign product_hi_nz = |acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered result and zero/carry/overflow flags
// Purpose: accepts one operation per in_valid/in_ready transfer and presents
//          a registered result and flags on an out_valid/out_ready port.
//          Single-cycle ops have latency 1 and full throughput; the optional
//          multiplier takes WIDTH BUSY cycles plus one DONE cycle.
// Ports:   clk, rst (sync, active high)
//          in_valid, in_ready        input handshake (in_ready low during rst)
//          a, b [WIDTH], op [4]      operands and opcode, captured on transfer
//          out_valid, out_ready      output handshake
//          result [WIDTH]            registered result
//          zero, carry, overflow     registered flags
// Config:  define ALU_SEQ_MUL_EN to compile in the MUL opcode, the BUSY/DONE
//          states and alu_mul_iter. Undefined, MUL decodes as unsupported and
//          the block is a pure one-stage pipeline.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  import alu_pkg::*;

  logic             xfer;
  logic             is_mul;
  logic             load_alu;
  logic             load_mul;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             sub_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH-1:0] mul_lo;
  logic             mul_hi_nz;

  assign xfer     = in_valid && in_ready;
  assign load_alu = xfer && !is_mul;

  // Single-cycle datapath. SUB is a + ~b + 1 so bit WIDTH is the no-borrow
  // carry; SLT reuses the subtractor and corrects the sign with overflow.
  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_NOR: alu_res = ~(a | b);
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = sub_ovf;
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, sub_full[WIDTH-1] ^ sub_ovf};
      default: ;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  state_t state;
  state_t state_next;
  logic   mul_done;

  assign is_mul = (op == OP_MUL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    load_mul   = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = !rst && (!out_valid || out_ready);
        if (in_valid && in_ready && is_mul) begin
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // Output register is guaranteed free here: a MUL is only accepted
        // when the register is empty or draining on that same edge.
        load_mul   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk           (clk),
    .rst           (rst),
    .start         (xfer && is_mul),
    .a             (a),
    .b             (b),
    .run           (state == ST_BUSY),
    .done          (mul_done),
    .product_lo    (mul_lo),
    .product_hi_nz (mul_hi_nz)
  );
`else
  assign is_mul    = 1'b0;
  assign load_mul  = 1'b0;
  assign mul_lo    = '0;
  assign mul_hi_nz = 1'b0;
  assign in_ready  = !rst && (!out_valid || out_ready);
`endif

  // Output register: a new load wins over a drain, so drain+accept on the
  // same edge keeps out_valid high. zero is derived from the value being
  // loaded so it lives in the same register stage as result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else if (load_alu) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      zero      <= (alu_res == '0);
      carry     <= alu_c;
      overflow  <= alu_v;
    end else if (load_mul) begin
      out_valid <= 1'b1;
      result    <= mul_lo;
      zero      <= (mul_lo == '0);
      carry     <= mul_hi_nz;
      overflow  <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (WIDTH=32)
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic [3:0]   op        = 4'b0000;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         overflow;

  int tests = 0;
  int fails = 0;
  int n_out = 0;

  // Reference state: one output slot plus at most one pending multiply.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_res   = '0;
  logic         m_c     = 1'b0;
  logic         m_v     = 1'b0;
  logic         m_pend  = 1'b0;
  int           m_rem   = 0;
  logic [W-1:0] p_res   = '0;
  logic         p_c     = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected result from the arithmetic definitions, in 64-bit integers.
  function automatic void calc(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                               output logic [31:0] r, output logic c, output logic v);
    longint unsigned ux, uy, p;
    longint sx, sy, s;
    ux = x; uy = y;
    sx = $signed(x); sy = $signed(y);
    r = '0; c = 1'b0; v = 1'b0;
    case (o)
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_NOR: r = ~(x | y);
      OP_ADD: begin
        p = ux + uy; r = p[31:0]; c = (p >= 64'h1_0000_0000);
        s = sx + sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SUB: begin
        r = x - y; c = (x >= y);
        s = sx - sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SLT: r = (sx < sy) ? 32'd1 : 32'd0;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin
        p = ux * uy; r = p[31:0]; c = ((p >> 32) != 0);
      end
`endif
      default: ;
    endcase
  endfunction

  // Compare DUT against the reference each cycle, then advance the reference
  // by the transaction the current inputs describe.
  always @(negedge clk) begin : model_cmp
    logic er, xfer, drain, mulop, cv, vv;
    logic [31:0] rr;
    er = !rst && !m_pend && (!m_valid || out_ready);
    chk("in_ready", in_ready, er);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("result", result, m_res);
      chk("zero", zero, m_res == '0);
      chk("carry", carry, m_c);
      chk("overflow", overflow, m_v);
    end
    if (out_valid && out_ready) n_out <= n_out + 1;
    xfer  = in_valid && er;
    drain = m_valid && out_ready;
    mulop = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    mulop = (op == OP_MUL);
`endif
    calc(op, a, b, rr, cv, vv);
    if (rst) begin
      m_valid <= 1'b0; m_res <= '0; m_c <= 1'b0; m_v <= 1'b0;
      m_pend <= 1'b0; m_rem <= 0;
    end else if (m_pend) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_pend <= 1'b0; m_valid <= 1'b1; m_res <= p_res; m_c <= p_c; m_v <= 1'b0;
      end
    end else if (xfer && mulop) begin
      m_pend <= 1'b1; m_rem <= W + 1; p_res <= rr; p_c <= cv; m_valid <= 1'b0;
    end else if (xfer) begin
      m_valid <= 1'b1; m_res <= rr; m_c <= cv; m_v <= vv;
    end else if (drain) begin
      m_valid <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1; op = o; a = x; b = y;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic [W-1:0] r, input logic z,
                         input logic c, input logic v);
    chk({name, ".valid"}, out_valid, 1'b1);
    chk({name, ".result"}, result, r);
    chk({name, ".zero"}, zero, z);
    chk({name, ".carry"}, carry, c);
    chk({name, ".overflow"}, overflow, v);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, ".valid"}, out_valid, 1'b0);
    chk({name, ".result"}, result, 32'h0);
    chk({name, ".zero"}, zero, 1'b1);
    chk({name, ".carry"}, carry, 1'b0);
    chk({name, ".overflow"}, overflow, 1'b0);
    chk({name, ".in_ready"}, in_ready, 1'b0);
  endtask

  initial begin : stim
    logic [31:0] r;
    logic c, v;
    int n0, lat;

    // Pin the reference arithmetic with hand-computed values.
    calc(OP_ADD, 32'hFFFF_FFFF, 32'h1, r, c, v);
    chk("model.add", {r, c, v}, {32'h0, 1'b1, 1'b0});
    calc(OP_SUB, 32'h8000_0000, 32'h1, r, c, v);
    chk("model.sub", {r, c, v}, {32'h7FFF_FFFF, 1'b1, 1'b1});
    calc(OP_SLT, 32'hFFFF_FFFF, 32'h1, r, c, v);
    chk("model.slt", r, 32'h1);
    calc(OP_ADD, 32'h7FFF_FFFF, 32'h1, r, c, v);
    chk("model.add_ovf", {r, c, v}, {32'h8000_0000, 1'b0, 1'b1});

    repeat (2) step();
    chk_reset_vals("reset");
    rst = 1'b0;
    #1;
    chk("reset.in_ready_after", in_ready, 1'b1);

    // ADD with carry out and zero result, latency exactly one cycle.
    out_ready = 1'b1;
    in_valid = 1'b1; op = OP_ADD; a = 32'hFFFF_FFFF; b = 32'h1;
    chk("add.pre_valid", out_valid, 1'b0);
    step();
    in_valid = 1'b0;
    chk_out("add", 32'h0, 1'b1, 1'b1, 1'b0);

    send(OP_SUB, 32'h8000_0000, 32'h1);
    chk_out("sub", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    send(OP_SLT, 32'hFFFF_FFFF, 32'h1);
    chk_out("slt", 32'h1, 1'b0, 1'b0, 1'b0);
    send(OP_SLT, 32'h1, 32'hFFFF_FFFF);
    chk_out("slt_false", 32'h0, 1'b1, 1'b0, 1'b0);
    send(OP_NOR, 32'h0, 32'h0);
    chk_out("nor", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    send(4'b0011, 32'h5, 32'h5);
    chk_out("unsupported", 32'h0, 1'b1, 1'b0, 1'b0);

    // Backpressure: result must hold while the consumer stalls.
    send(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    out_ready = 1'b0;
    chk_out("bp.and", 32'hF000_F000, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; op = OP_OR; a = 32'h0000_000F; b = 32'h0000_00F0;
    #1;
    chk("bp.in_ready_low", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp.hold_valid", out_valid, 1'b1);
      chk("bp.hold_result", result, 32'hF000_F000);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_high", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk_out("bp.or", 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    chk("bp.drained", out_valid, 1'b0);

    // Back-to-back: eight ADDs, one result per cycle.
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      send(OP_ADD, i * 32'h1111_1111, i);
      chk("b2b.valid", out_valid, 1'b1);
      chk("b2b.result", result, i * 32'h1111_1111 + i);
    end
    step();
    chk("b2b.count", n_out - n0, 8);

`ifdef ALU_SEQ_MUL_EN
    // MUL with product overflowing into the high half.
    send(OP_MUL, 32'h0001_0000, 32'h0001_0000);
    lat = 0;
    while (!out_valid && lat < 100) begin
      chk("mul.in_ready_busy", in_ready, 1'b0);
      step();
      lat++;
    end
    chk("mul.latency", lat, W + 1);
    chk_out("mul.big", 32'h0, 1'b1, 1'b1, 1'b0);
    chk("mul.in_ready_done", in_ready, 1'b1);
    send(OP_MUL, 32'd7, 32'd6);
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    chk("mul.latency2", lat, W + 1);
    chk_out("mul.small", 32'd42, 1'b0, 1'b0, 1'b0);
    step();
`else
    // Without the multiplier MUL is an unsupported opcode.
    send(OP_MUL, 32'd7, 32'd6);
    chk_out("mul.unsupported", 32'h0, 1'b1, 1'b0, 1'b0);
    step();
`endif

    // Reset while a result is being held.
    out_ready = 1'b0;
    send(OP_ADD, 32'h1, 32'h1);
    chk_out("rst.held", 32'h2, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk_reset_vals("rst.held_clear");
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst.held_ready", in_ready, 1'b1);

`ifdef ALU_SEQ_MUL_EN
    // Reset on the 10th BUSY cycle aborts the multiply for good.
    send(OP_MUL, 32'd3, 32'd5);
    repeat (9) step();
    rst = 1'b1;
    step();
    chk_reset_vals("rst.mul");
    rst = 1'b0;
    #1;
    chk("rst.mul_ready", in_ready, 1'b1);
    for (int i = 0; i < 40; i++) begin
      step();
      chk("rst.mul_no_stale", out_valid, 1'b0);
    end
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
